// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one imem read at a time,
// hands each instruction to decode and handles redirects and misaligned targets.
//
// state | meaning
// IDLE  | no fetch in flight; waits for fetch_en
// REQ   | imem_req high, imem_addr held until imem_gnt
// WAIT  | request granted; waiting for imem_rvalid
// HOLD  | instruction presented to decode until instr_ready or redirect
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        misalign_err,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] shadow_pc, shadow_nxt;
  logic        redir_pend, redir_pend_nxt;
  logic        discard, discard_nxt;
  logic        load_instr;
  logic        misaligned;
  logic [31:0] target;

  assign misaligned  = redirect_valid && (redirect_addr[1:0] != 2'b00);
  assign target      = misaligned ? TRAP_VECTOR : redirect_addr;
  assign imem_req    = (state == REQ);
  assign instr_valid = (state == HOLD);
  assign imem_addr   = pc;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    shadow_nxt     = shadow_pc;
    redir_pend_nxt = redir_pend;
    discard_nxt    = discard;
    load_instr     = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid) pc_nxt = target;
        if (fetch_en) state_nxt = REQ;
      end
      REQ: begin
        if (imem_gnt) begin
          state_nxt = WAIT;
          if (redirect_valid) begin
            pc_nxt         = target;
            discard_nxt    = 1'b1;
            redir_pend_nxt = 1'b0;
          end
        end else if (redirect_valid) begin
          // imem_addr must stay put until the grant, so park the target
          shadow_nxt     = target;
          redir_pend_nxt = 1'b1;
          discard_nxt    = 1'b1;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_nxt         = target;
          discard_nxt    = 1'b1;
          redir_pend_nxt = 1'b0;
        end
        if (imem_rvalid) begin
          if (discard || redirect_valid) begin
            discard_nxt    = 1'b0;
            redir_pend_nxt = 1'b0;
            state_nxt      = REQ;
            if (!redirect_valid && redir_pend) pc_nxt = shadow_pc;
          end else begin
            load_instr = 1'b1;
            state_nxt  = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid || instr_ready) begin
          pc_nxt    = redirect_valid ? target : instr_pc + 32'd4;
          state_nxt = fetch_en ? REQ : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      shadow_pc    <= '0;
      redir_pend   <= 1'b0;
      discard      <= 1'b0;
      instr        <= '0;
      instr_pc     <= '0;
      misalign_err <= 1'b0;
      err_addr     <= '0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      shadow_pc    <= shadow_nxt;
      redir_pend   <= redir_pend_nxt;
      discard      <= discard_nxt;
      misalign_err <= misaligned;
      if (misaligned) err_addr <= redirect_addr;
      if (load_instr) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a transaction-level model of the fetch
// stream (architectural next-PC, outstanding/stale request, held instruction).
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP     = 32'h0000_0100;

  logic clk = 1'b0, rst = 1'b0;
  logic fetch_en = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0, instr_ready = 1'b0;
  logic redirect_valid = 1'b0;
  logic [31:0] imem_rdata = '0, redirect_addr = '0;
  logic imem_req, instr_valid, misalign_err;
  logic [31:0] imem_addr, instr, instr_pc, err_addr;

  fetch_sequencer #(.RESET_PC(RESET_PC), .TRAP_VECTOR(TRAP)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .misalign_err(misalign_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model
  logic [31:0] m_fetch, m_req_addr, m_instr, m_ipc, m_eaddr;
  bit m_out, m_granted, m_stale, m_hold, m_merr;

  // memory responder
  bit mem_pend;
  int mem_dly, mem_lo, mem_hi;
  bit force_data;
  logic [31:0] force_val;

  // last sampled outputs
  logic last_req, last_valid, last_merr;
  logic [31:0] last_addr, last_instr, last_ipc, last_eaddr;

  task automatic model_reset();
    m_fetch = RESET_PC; m_req_addr = '0; m_instr = '0; m_ipc = '0; m_eaddr = '0;
    m_out = 0; m_granted = 0; m_stale = 0; m_hold = 0; m_merr = 0;
  endtask

  task automatic cycle(input bit fe, input bit gnt_en, input bit rdy, input bit rv,
                       input logic [31:0] rt);
    logic [31:0] np;
    bit set_hold;
    @(negedge clk);
    last_req = imem_req; last_addr = imem_addr; last_valid = instr_valid;
    last_instr = instr; last_ipc = instr_pc; last_merr = misalign_err; last_eaddr = err_addr;
    chk("instr_valid", {31'd0, last_valid}, {31'd0, m_hold});
    if (m_hold) begin
      chk("instr", last_instr, m_instr);
      chk("instr_pc", last_ipc, m_ipc);
    end
    chk("misalign_err", {31'd0, last_merr}, {31'd0, m_merr});
    chk("err_addr", last_eaddr, m_eaddr);
    if (m_granted) chk("req_while_waiting", {31'd0, last_req}, 32'd0);
    else if (last_req) chk("req_addr", last_addr, m_out ? m_req_addr : m_fetch);

    fetch_en = fe; instr_ready = rdy; redirect_valid = rv; redirect_addr = rt;
    imem_gnt = last_req && gnt_en;
    imem_rvalid = mem_pend && (mem_dly == 0);
    imem_rdata = (imem_rvalid && force_data) ? force_val : $urandom;
    @(posedge clk);

    if (imem_rvalid) mem_pend = 0;
    else if (mem_pend) mem_dly--;
    if (imem_gnt) begin
      mem_pend = 1;
      mem_dly = $urandom_range(mem_hi, mem_lo);
    end

    if (!rst) begin
      model_reset();
    end else begin
      np = (rt[1:0] == 2'b00) ? rt : TRAP;
      m_merr = rv && (rt[1:0] != 2'b00);
      if (m_merr) m_eaddr = rt;
      set_hold = 0;
      if (imem_rvalid && m_granted) begin
        if (!m_stale && !rv) begin
          set_hold = 1; m_instr = imem_rdata; m_ipc = m_req_addr;
        end
        m_out = 0; m_granted = 0; m_stale = 0;
      end
      if (last_req && !m_out) begin m_out = 1; m_req_addr = last_addr; end
      if (last_req && imem_gnt) m_granted = 1;
      if (m_hold && (rdy || rv)) begin
        m_hold = 0;
        if (!rv) m_fetch = m_ipc + 32'd4;
      end
      if (set_hold) m_hold = 1;
      if (rv) begin
        m_fetch = np;
        if (m_out) m_stale = 1;
      end
    end
  endtask

  task automatic wait_req(input bit gnt_en);
    int n = 0;
    do begin
      cycle(1, gnt_en, 1, 0, '0);
      n++;
    end while (!last_req && n < 20);
    if (!last_req) chk("wait_req_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      cycle(1, 1, 0, 0, '0);
      n++;
    end while (!last_valid && n < 20);
    if (!last_valid) chk("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] old_addr, i0, p0, rt;
    model_reset();
    mem_pend = 0; mem_dly = 0; mem_lo = 0; mem_hi = 0; force_data = 0; force_val = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;

    // sequential fetch with minimum latency
    for (int i = 0; i < 3; i++) begin
      wait_req(1);
      chk("t1_addr", last_addr, 32'(i * 4));
      cycle(1, 1, 1, 0, '0);
      chk("t1_gnt_plus1_valid", {31'd0, last_valid}, 32'd0);
      cycle(1, 1, 1, 0, '0);
      chk("t1_gnt_plus2_valid", {31'd0, last_valid}, 32'd1);
    end

    // PC wrap at top of address space
    wait_valid();
    cycle(1, 1, 0, 1, 32'hFFFF_FFFC);
    wait_req(1);
    chk("t2_top_addr", last_addr, 32'hFFFF_FFFC);
    wait_valid();
    cycle(1, 1, 1, 0, '0);
    wait_req(1);
    chk("t2_wrap_addr", last_addr, 32'h0000_0000);

    // redirect in WAIT together with rvalid
    force_data = 1; force_val = 32'h0000_DEAD;
    cycle(1, 1, 1, 1, 32'h200);
    cycle(1, 1, 1, 0, '0);
    chk("t3_no_valid", {31'd0, last_valid}, 32'd0);
    chk("t3_req", {31'd0, last_req}, 32'd1);
    chk("t3_addr", last_addr, 32'h200);
    force_data = 0;

    // redirect during REQ while grant is withheld
    wait_req(0);
    old_addr = last_addr;
    cycle(1, 0, 1, 1, 32'h40);
    cycle(1, 0, 1, 0, '0);
    chk("t4_addr_held1", last_addr, old_addr);
    cycle(1, 1, 1, 0, '0);
    chk("t4_addr_held2", last_addr, old_addr);
    cycle(1, 1, 1, 0, '0);
    chk("t4_dropped", {31'd0, last_valid}, 32'd0);
    cycle(1, 1, 1, 0, '0);
    chk("t4_req", {31'd0, last_req}, 32'd1);
    chk("t4_addr", last_addr, 32'h40);

    // misaligned redirect
    wait_valid();
    cycle(1, 1, 0, 1, 32'h102);
    cycle(1, 1, 1, 0, '0);
    chk("t5_merr", {31'd0, last_merr}, 32'd1);
    chk("t5_err_addr", last_eaddr, 32'h102);
    chk("t5_trap_addr", last_addr, TRAP);
    cycle(1, 1, 1, 0, '0);
    chk("t5_merr_pulse", {31'd0, last_merr}, 32'd0);

    // stall in HOLD, flush by redirect, then reset mid-WAIT
    wait_valid();
    i0 = last_instr; p0 = last_ipc;
    for (int k = 0; k < 4; k++) begin
      cycle(1, 1, 0, 0, '0);
      chk("t6_instr_stable", last_instr, i0);
      chk("t6_pc_stable", last_ipc, p0);
    end
    cycle(1, 1, 0, 1, 32'h300);
    mem_lo = 2; mem_hi = 2;
    cycle(1, 1, 1, 0, '0);
    chk("t6_flushed", {31'd0, last_valid}, 32'd0);
    chk("t6_addr", last_addr, 32'h300);
    #2 rst = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_merr", {31'd0, misalign_err}, 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("rst_pc", imem_addr, RESET_PC);
    model_reset();
    cycle(0, 1, 1, 0, '0);
    cycle(0, 1, 1, 0, '0);
    #3 rst = 1'b1;
    for (int k = 0; k < 3; k++) cycle(0, 1, 1, 0, '0);
    chk("late_rvalid_ignored", {31'd0, last_valid}, 32'd0);
    chk("idle_no_req", {31'd0, last_req}, 32'd0);

    // randomized traffic
    mem_lo = 0; mem_hi = 2;
    for (int k = 0; k < 3000; k++) begin
      rt = $urandom_range(0, 4095);
      if (($urandom % 4) != 0) rt[1:0] = 2'b00;
      if (($urandom % 50) == 0) rt = 32'hFFFF_FFFC;
      cycle(($urandom % 10) != 0, ($urandom % 2) == 0, ($urandom % 3) != 0,
            ($urandom % 12) == 0, rt);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
